// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-ported data memory.
// It grants one port, makes one dmem access, returns a one-cycle response and rejects misaligned or illegal-size commands.
module dmem_arbiter #(
    parameter int unsigned XLEN      = 32,
    parameter bit          CORE_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            c_req,
    input  logic            c_we,
    input  logic [XLEN-1:0] c_addr,
    input  logic [XLEN-1:0] c_wdata,
    input  logic [1:0]      c_size,
    input  logic            c_lu,
    output logic            c_gnt,
    output logic            c_rvalid,
    output logic [XLEN-1:0] c_rdata,
    output logic            c_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [1:0]      d_size,
    input  logic            d_lu,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_err,
    output logic            m_we,
    output logic [XLEN-1:0] m_a,
    output logic [XLEN-1:0] m_wd,
    output logic [1:0]      m_lwhb,
    output logic [1:0]      m_swhb,
    output logic            m_lu,
    input  logic [XLEN-1:0] m_rd,
    output logic            busy
);

    localparam int unsigned SZ_W = 2;
    localparam logic [SZ_W-1:0] SZ_ILL  = 2'b00;
    localparam logic [SZ_W-1:0] SZ_HALF = 2'b10;
    localparam logic [SZ_W-1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_d_q;
    logic   own_d_q;
    logic   err_q;
    logic   pick_d;
    logic   grant;

    logic            win_we;
    logic [XLEN-1:0] win_addr;
    logic [XLEN-1:0] win_wdata;
    logic [SZ_W-1:0] win_size;
    logic            win_lu;
    logic            win_err;
    logic [XLEN-1:0] load_data;

    // D wins a tie only when round-robin is on and C was served last
    assign pick_d = d_req && (!c_req || (!CORE_PRIO && !last_d_q));
    assign grant  = c_gnt | d_gnt;
    assign busy   = (state_q != IDLE);

    always_comb begin : fsm_next
        state_d = state_q;
        c_gnt   = 1'b0;
        d_gnt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (c_req || d_req) begin
                    c_gnt   = !pick_d;
                    d_gnt   = pick_d;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin : fsm_reg
        if (!rstn) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (grant) last_d_q <= d_gnt;
        end
    end

    assign win_we    = d_gnt ? d_we    : c_we;
    assign win_addr  = d_gnt ? d_addr  : c_addr;
    assign win_wdata = d_gnt ? d_wdata : c_wdata;
    assign win_size  = d_gnt ? d_size  : c_size;
    assign win_lu    = d_gnt ? d_lu    : c_lu;
    assign win_err   = (win_size == SZ_ILL)
                     || (win_size == SZ_HALF && win_addr[0])
                     || (win_size == SZ_WORD && win_addr[1:0] != 2'b00);

    // m_lwhb is nonzero only for a legal load, so it doubles as the capture qualifier
    assign load_data = (m_lwhb != SZ_ILL) ? m_rd : '0;

    // m_* hold the latched command for the ACCESS cycle only; responses live for RESP only
    always_ff @(posedge clk or negedge rstn) begin : dpath
        if (!rstn) begin
            own_d_q  <= 1'b0;
            err_q    <= 1'b0;
            m_we     <= 1'b0;
            m_a      <= '0;
            m_wd     <= '0;
            m_lwhb   <= '0;
            m_swhb   <= '0;
            m_lu     <= 1'b0;
            c_rvalid <= 1'b0;
            c_rdata  <= '0;
            c_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            m_we     <= 1'b0;
            m_a      <= '0;
            m_wd     <= '0;
            m_lwhb   <= '0;
            m_swhb   <= '0;
            m_lu     <= 1'b0;
            c_rvalid <= 1'b0;
            c_rdata  <= '0;
            c_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
            if (grant) begin
                own_d_q <= d_gnt;
                err_q   <= win_err;
                if (!win_err) begin
                    m_we   <= win_we;
                    m_a    <= win_addr;
                    m_wd   <= win_wdata;
                    m_lu   <= win_lu;
                    m_lwhb <= win_we ? SZ_ILL : win_size;
                    m_swhb <= win_we ? win_size : SZ_ILL;
                end
            end
            if (state_q == ACCESS) begin
                c_rvalid <= !own_d_q;
                d_rvalid <= own_d_q;
                c_rdata  <= own_d_q ? '0 : load_data;
                d_rdata  <= own_d_q ? load_data : '0;
                c_err    <= !own_d_q && err_q;
                d_err    <= own_d_q && err_q;
            end
        end
    end

endmodule
